// File: rtl/gf_mul_arbiter_pkg.sv
// Shared GCM datapath types and constants.
package gcm_pkg;

   typedef logic [127:0] gf128_t;

   // Multiplicative identity in GCM's reflected bit order
   localparam gf128_t GF_ONE = 128'h8000_0000_0000_0000_0000_0000_0000_0000;

   localparam int unsigned DEF_MUL_LAT = 5;
   localparam int unsigned MAX_TAG_W   = 3;

   typedef struct packed {
      logic                 valid;
      logic [MAX_TAG_W-1:0] idx;
   } mul_tag_t;

endpackage

// File: rtl/gf_mul_arbiter_if.sv
// Requester-side bundle: request handshake, operands and product broadcast.
interface gf_mul_arbiter_if #(
   parameter int unsigned NUM_REQ = 3
);
   import gcm_pkg::*;

   logic [NUM_REQ-1:0]     req_valid;
   logic [NUM_REQ-1:0]     req_ready;
   logic [NUM_REQ*128-1:0] req_a;
   logic [NUM_REQ*128-1:0] req_b;
   logic [NUM_REQ-1:0]     rsp_valid;
   gf128_t                 rsp_data;

   modport master (
      output req_valid, req_a, req_b,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, req_a, req_b,
      output req_ready, rsp_valid, rsp_data
   );

endinterface

// File: rtl/gf_mul_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after the pointer.
module rr_arbiter #(
   parameter  int unsigned N = 3,
   localparam int unsigned W = (N > 1) ? $clog2(N) : 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [N-1:0] req,
   output logic [N-1:0] grant,
   output logic [W-1:0] idx
);

   logic [W-1:0] ptr;
   logic [W-1:0] cand;
   int unsigned  pos;
   logic         found;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      pos   = 0;
      cand  = '0;
      for (int unsigned i = 0; i < N; i++) begin
         pos = 32'(ptr) + i;
         if (pos >= N) pos = pos - N;
         cand = W'(pos);
         if (!found && req[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            idx         = cand;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         ptr <= '0;
      else if (en && found)
         ptr <= (idx == W'(N - 1)) ? '0 : idx + W'(1);
   end

endmodule

// File: rtl/gf_mul_arbiter.sv
// Shares one pipelined GF(2^128) multiplier among NUM_REQ requesters and routes
// each product back to its issuer through a tag pipeline.
module gf_mul_arbiter
   import gcm_pkg::*;
#(
   parameter int unsigned NUM_REQ = 3,
   parameter int unsigned MUL_LAT = DEF_MUL_LAT,
   parameter int unsigned TAG_W   = $clog2(NUM_REQ)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   gf_mul_arbiter_if.slave  bus,
   output logic             mul_valid_o,
   output gf128_t           mul_a_o,
   output gf128_t           mul_b_o,
   input  gf128_t           mul_res_i,
   output logic             busy
);

   logic [NUM_REQ-1:0] arb_req;
   logic [NUM_REQ-1:0] grant;
   logic [TAG_W-1:0]   g_idx;
   gf128_t             sel_a, sel_b;
   gf128_t             a_q, b_q, rsp_data_q;
   logic [NUM_REQ-1:0] rsp_valid_q, rsp_next;
   mul_tag_t           tag_in;

   // Stage 0 is the issue stage (drives mul_valid_o); stage MUL_LAT lines up with mul_res_i.
   mul_tag_t tag_q [0:MUL_LAT];

   assign arb_req = (rst || flush) ? '0 : bus.req_valid;

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .clk   (clk),
      .rst   (rst | flush),
      .en    (1'b1),
      .req   (arb_req),
      .grant (grant),
      .idx   (g_idx)
   );

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_a = bus.req_a[128*i +: 128];
            sel_b = bus.req_b[128*i +: 128];
         end
      end
      tag_in       = '0;
      tag_in.valid = |grant;
      tag_in.idx   = MAX_TAG_W'(g_idx);
   end

   always_comb begin
      rsp_next = '0;
      if (tag_q[MUL_LAT].valid)
         rsp_next[tag_q[MUL_LAT].idx[TAG_W-1:0]] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned k = 0; k <= MUL_LAT; k++) tag_q[k] <= '0;
         a_q         <= '0;
         b_q         <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
      end else begin
         if (|grant) begin
            a_q <= sel_a;
            b_q <= sel_b;
         end
         tag_q[0] <= tag_in;
         for (int unsigned k = 1; k <= MUL_LAT; k++)
            tag_q[k] <= flush ? '0 : tag_q[k-1];
         rsp_valid_q <= flush ? '0 : rsp_next;
         if (!flush && tag_q[MUL_LAT].valid)
            rsp_data_q <= mul_res_i;
      end
   end

   always_comb begin
      busy = |rsp_valid_q;
      for (int unsigned k = 0; k <= MUL_LAT; k++)
         busy = busy | tag_q[k].valid;
   end

   assign bus.req_ready = grant;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign mul_valid_o   = tag_q[0].valid;
   assign mul_a_o       = a_q;
   assign mul_b_o       = b_q;

endmodule

// File: tb/tb_gf_mul_arbiter.sv
// Directed bench for gf_mul_arbiter with a behavioural MUL_LAT-cycle GF(2^128) multiplier.
module tb_gf_mul_arbiter;
   import gcm_pkg::*;

   localparam int unsigned NR  = 3;
   localparam int unsigned LAT = 5;
   localparam gf128_t JUNK = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;

   logic   clk = 1'b0;
   logic   rst = 1'b1;
   logic   flush = 1'b0;
   logic   mul_valid_o;
   gf128_t mul_a_o, mul_b_o, mul_res_i;
   logic   busy;

   int vectors = 0;
   int miscompares = 0;

   gf_mul_arbiter_if #(.NUM_REQ(NR)) bus ();

   gf_mul_arbiter #(.NUM_REQ(NR), .MUL_LAT(LAT)) dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .bus         (bus),
      .mul_valid_o (mul_valid_o),
      .mul_a_o     (mul_a_o),
      .mul_b_o     (mul_b_o),
      .mul_res_i   (mul_res_i),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   function automatic gf128_t gf_mul(input gf128_t x, input gf128_t y);
      gf128_t z = '0;
      gf128_t v = y;
      for (int i = 0; i < 128; i++) begin
         if (x[127-i]) z = z ^ v;
         if (v[0]) v = (v >> 1) ^ {8'hE1, 120'h0};
         else      v = v >> 1;
      end
      return z;
   endfunction

   // Issue at T+1 -> product on mul_res_i at T+1+LAT
   gf128_t mpipe [LAT];
   always @(posedge clk) begin
      mpipe[0] <= mul_valid_o ? gf_mul(mul_a_o, mul_b_o) : JUNK;
      for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
   end
   assign mul_res_i = mpipe[LAT-1];

   task automatic test_reset();
      @(negedge clk);
      bus.req_valid = '1;
      #1;
      vectors++;
      if (bus.req_ready !== 3'b000) begin
         miscompares++; $display("FAIL reset_ready got %b want 000", bus.req_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      bus.req_valid = '0;
      #1;
      vectors++;
      if ({mul_valid_o, bus.rsp_valid, busy} !== 5'b0) begin
         miscompares++; $display("FAIL reset_ctrl got mv=%b rv=%b busy=%b want 0", mul_valid_o, bus.rsp_valid, busy);
      end
      vectors++;
      if (mul_a_o !== '0 || mul_b_o !== '0 || bus.rsp_data !== '0) begin
         miscompares++; $display("FAIL reset_data got a=%h b=%h r=%h want 0", mul_a_o, mul_b_o, bus.rsp_data);
      end
      @(negedge clk);
   endtask

   task automatic test_simultaneous();
      gf128_t bv [NR] = '{128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                          128'hA5A5_5A5A_0F0F_F0F0_3C3C_C3C3_9696_6969,
                          128'h1111_2222_3333_4444_5555_6666_7777_8888};
      logic [NR-1:0] er;
      for (int i = 0; i < NR; i++) begin
         bus.req_a[128*i +: 128] = GF_ONE;
         bus.req_b[128*i +: 128] = bv[i];
      end
      bus.req_valid = '1;
      for (int c = 0; c <= 10; c++) begin
         if (c >= 1 && c <= 3) bus.req_valid[c-1] = 1'b0;
         #1;
         er = (c < 3) ? (3'b001 << c) : 3'b000;
         vectors++;
         if (bus.req_ready !== er) begin
            miscompares++; $display("FAIL simul_ready c=%0d got %b want %b", c, bus.req_ready, er);
         end
         if (c >= 1 && c <= 3) begin
            vectors++;
            if (mul_valid_o !== 1'b1 || mul_a_o !== GF_ONE || mul_b_o !== bv[c-1]) begin
               miscompares++; $display("FAIL simul_issue c=%0d got mv=%b b=%h want 1 %h", c, mul_valid_o, mul_b_o, bv[c-1]);
            end
         end
         er = (c >= 7 && c <= 9) ? (3'b001 << (c - 7)) : 3'b000;
         vectors++;
         if (bus.rsp_valid !== er) begin
            miscompares++; $display("FAIL simul_rsp c=%0d got %b want %b", c, bus.rsp_valid, er);
         end
         if (c >= 7 && c <= 9) begin
            vectors++;
            if (bus.rsp_data !== bv[c-7]) begin
               miscompares++; $display("FAIL simul_data c=%0d got %h want %h", c, bus.rsp_data, bv[c-7]);
            end
         end
         if (c == 10) begin
            vectors++;
            if (busy !== 1'b0) begin
               miscompares++; $display("FAIL simul_idle got busy=%b want 0", busy);
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_single();
      gf128_t b = 128'h66E9_4BD4_EF8A_2C3B_884C_FA59_CA34_2B2E;
      logic [NR-1:0] er;
      bus.req_a[127:0] = GF_ONE;
      bus.req_b[127:0] = b;
      bus.req_valid = 3'b001;
      for (int c = 0; c <= 8; c++) begin
         if (c == 1) bus.req_valid = '0;
         #1;
         er = (c == 0) ? 3'b001 : 3'b000;
         vectors++;
         if (bus.req_ready !== er) begin
            miscompares++; $display("FAIL single_ready c=%0d got %b want %b", c, bus.req_ready, er);
         end
         if (c == 1 || c == 2) begin
            vectors++;
            if (mul_valid_o !== (c == 1)) begin
               miscompares++; $display("FAIL single_mv c=%0d got %b want %b", c, mul_valid_o, c == 1);
            end
         end
         if (c == 1) begin
            vectors++;
            if (mul_a_o !== GF_ONE || mul_b_o !== b) begin
               miscompares++; $display("FAIL single_ops got a=%h b=%h want %h %h", mul_a_o, mul_b_o, GF_ONE, b);
            end
         end
         er = (c == 7) ? 3'b001 : 3'b000;
         vectors++;
         if (bus.rsp_valid !== er) begin
            miscompares++; $display("FAIL single_rsp c=%0d got %b want %b", c, bus.rsp_valid, er);
         end
         if (c >= 7) begin
            vectors++;
            if (bus.rsp_data !== b) begin
               miscompares++; $display("FAIL single_data c=%0d got %h want %h", c, bus.rsp_data, b);
            end
         end
         if (c == 8) begin
            vectors++;
            if (busy !== 1'b0) begin
               miscompares++; $display("FAIL single_idle got busy=%b want 0", busy);
            end
         end
         @(negedge clk);
      end
   endtask

   // Pointer is 1 on entry, so the alternation starts with requester 2
   task automatic test_fairness();
      gf128_t b0 = 128'hCAFE_0000_0000_0000_0000_0000_0000_0001;
      gf128_t b2 = 128'hBEEF_0000_0000_0000_0000_0000_0000_0002;
      logic [NR-1:0] er;
      int g;
      bus.req_a[0 +: 128]   = GF_ONE;
      bus.req_b[0 +: 128]   = b0;
      bus.req_a[256 +: 128] = GF_ONE;
      bus.req_b[256 +: 128] = b2;
      bus.req_valid = 3'b101;
      for (int c = 0; c <= 16; c++) begin
         if (c == 8) bus.req_valid = '0;
         #1;
         er = (c < 8) ? ((c % 2 == 0) ? 3'b100 : 3'b001) : 3'b000;
         vectors++;
         if (bus.req_ready !== er) begin
            miscompares++; $display("FAIL fair_ready c=%0d got %b want %b", c, bus.req_ready, er);
         end
         if (c >= 1 && c <= 8) begin
            g = ((c - 1) % 2 == 0) ? 2 : 0;
            vectors++;
            if (mul_valid_o !== 1'b1 || mul_b_o !== ((g == 2) ? b2 : b0)) begin
               miscompares++; $display("FAIL fair_issue c=%0d got mv=%b b=%h", c, mul_valid_o, mul_b_o);
            end
         end
         g = ((c - 7) % 2 == 0) ? 2 : 0;
         er = (c >= 7 && c <= 14) ? (3'b001 << g) : 3'b000;
         vectors++;
         if (bus.rsp_valid !== er) begin
            miscompares++; $display("FAIL fair_rsp c=%0d got %b want %b", c, bus.rsp_valid, er);
         end
         if (c >= 7 && c <= 14) begin
            vectors++;
            if (bus.rsp_data !== ((g == 2) ? b2 : b0)) begin
               miscompares++; $display("FAIL fair_data c=%0d got %h", c, bus.rsp_data);
            end
         end
         if (c == 16) begin
            vectors++;
            if (busy !== 1'b0) begin
               miscompares++; $display("FAIL fair_idle got busy=%b want 0", busy);
            end
         end
         @(negedge clk);
      end
   endtask

   // Pointer is 1 on entry: grants 1,2,0, then flush must drop them and reset the pointer
   task automatic test_flush();
      gf128_t bv [NR] = '{128'h0000_0000_0000_0000_0000_0000_0000_00A0,
                          128'h0000_0000_0000_0000_0000_0000_0000_00B1,
                          128'h0000_0000_0000_0000_0000_0000_0000_00C2};
      logic [NR-1:0] er;
      for (int i = 0; i < NR; i++) begin
         bus.req_a[128*i +: 128] = GF_ONE;
         bus.req_b[128*i +: 128] = bv[i];
      end
      bus.req_valid = '1;
      for (int c = 0; c <= 30; c++) begin
         if (c == 1) bus.req_valid[1] = 1'b0;
         if (c == 2) bus.req_valid[2] = 1'b0;
         if (c == 3) begin bus.req_valid[0] = 1'b0; flush = 1'b1; end
         if (c == 4) flush = 1'b0;
         if (c == 21) bus.req_valid = 3'b011;
         if (c == 22) bus.req_valid[0] = 1'b0;
         if (c == 23) bus.req_valid[1] = 1'b0;
         #1;
         case (c)
            0:       er = 3'b010;
            1:       er = 3'b100;
            2:       er = 3'b001;
            21:      er = 3'b001;
            22:      er = 3'b010;
            default: er = 3'b000;
         endcase
         vectors++;
         if (bus.req_ready !== er) begin
            miscompares++; $display("FAIL flush_ready c=%0d got %b want %b", c, bus.req_ready, er);
         end
         if (c >= 4 && c <= 20) begin
            vectors++;
            if (bus.rsp_valid !== 3'b000 || busy !== 1'b0) begin
               miscompares++; $display("FAIL flush_drop c=%0d got rv=%b busy=%b want 000 0", c, bus.rsp_valid, busy);
            end
         end
         if (c >= 21) begin
            er = (c == 28) ? 3'b001 : (c == 29) ? 3'b010 : 3'b000;
            vectors++;
            if (bus.rsp_valid !== er) begin
               miscompares++; $display("FAIL flush_resume c=%0d got %b want %b", c, bus.rsp_valid, er);
            end
            if (c == 28 || c == 29) begin
               vectors++;
               if (bus.rsp_data !== bv[c-28]) begin
                  miscompares++; $display("FAIL flush_data c=%0d got %h want %h", c, bus.rsp_data, bv[c-28]);
               end
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_flush_with_request();
      gf128_t b = 128'h7777_0000_1234_5678_9ABC_DEF0_0000_7777;
      logic [NR-1:0] er;
      bus.req_a[128 +: 128] = GF_ONE;
      bus.req_b[128 +: 128] = b;
      bus.req_valid = 3'b010;
      flush = 1'b1;
      for (int c = 0; c <= 9; c++) begin
         if (c == 1) flush = 1'b0;
         if (c == 2) bus.req_valid = '0;
         #1;
         er = (c == 1) ? 3'b010 : 3'b000;
         vectors++;
         if (bus.req_ready !== er) begin
            miscompares++; $display("FAIL fwr_ready c=%0d got %b want %b", c, bus.req_ready, er);
         end
         if (c == 2) begin
            vectors++;
            if (mul_valid_o !== 1'b1 || mul_b_o !== b) begin
               miscompares++; $display("FAIL fwr_issue got mv=%b b=%h want 1 %h", mul_valid_o, mul_b_o, b);
            end
         end
         er = (c == 8) ? 3'b010 : 3'b000;
         vectors++;
         if (bus.rsp_valid !== er) begin
            miscompares++; $display("FAIL fwr_rsp c=%0d got %b want %b", c, bus.rsp_valid, er);
         end
         if (c == 8) begin
            vectors++;
            if (bus.rsp_data !== b) begin
               miscompares++; $display("FAIL fwr_data got %h want %h", bus.rsp_data, b);
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid();
      gf128_t b = 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA;
      bus.req_a[256 +: 128] = GF_ONE;
      bus.req_b[256 +: 128] = b;
      bus.req_valid = 3'b100;
      for (int c = 0; c <= 17; c++) begin
         if (c == 1) bus.req_valid = '0;
         if (c == 6) rst = 1'b1;
         if (c == 7) rst = 1'b0;
         #1;
         if (c == 6) begin
            vectors++;
            if (busy !== 1'b1) begin
               miscompares++; $display("FAIL rstmid_busy got %b want 1", busy);
            end
         end
         if (c == 7) begin
            vectors++;
            if ({mul_valid_o, busy} !== 2'b00 || mul_a_o !== '0 || mul_b_o !== '0 || bus.rsp_data !== '0) begin
               miscompares++; $display("FAIL rstmid_clear got mv=%b busy=%b a=%h b=%h r=%h want 0",
                                       mul_valid_o, busy, mul_a_o, mul_b_o, bus.rsp_data);
            end
         end
         if (c >= 7) begin
            vectors++;
            if (bus.rsp_valid !== 3'b000) begin
               miscompares++; $display("FAIL rstmid_rsp c=%0d got %b want 000", c, bus.rsp_valid);
            end
         end
         @(negedge clk);
      end
   endtask

   initial begin
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      test_reset();
      test_simultaneous();
      test_single();
      test_fairness();
      test_flush();
      test_flush_with_request();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
